// File: rtl/apb2axi_wr_issuer.sv
// apb2axi_wr_issuer
//
// Takes single-beat write commands from a command FIFO and issues each one as
// an AXI write: one AW beat, one W beat (awlen=0), then waits for the B
// response. Only one write is outstanding at a time. It runs as a three-state
// FSM: IDLE -> ISSUE -> RESP -> IDLE.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where valid and ready are both high. A valid, once raised, stays high with a
// stable payload until that transfer happens.
//
// Optional feature: define APB2AXI_WR_ERR_CNT_EN to add the err_cnt port. It
// is a saturating count of B responses with bresp[1]=1 (SLVERR/DECERR).
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_data command FIFO pop side, entry = {strb, data, addr}
//   aw* / awvalid / awready      AXI write-address channel
//   wdata/wstrb/wlast/wvalid/wready  AXI write-data channel
//   bid/bresp/bvalid/bready      AXI write-response channel (bid is ignored)
//   done_valid/done_resp         one-cycle completion pulse with the bresp
//   busy                         high whenever the FSM is not in IDLE
//   err_cnt                      error count (only with APB2AXI_WR_ERR_CNT_EN)
module apb2axi_wr_issuer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [ADDR_W+DATA_W+DATA_W/8-1:0]     cmd_data,
  output logic [ID_W-1:0]                       awid,
  output logic [ADDR_W-1:0]                     awaddr,
  output logic [7:0]                            awlen,
  output logic [2:0]                            awsize,
  output logic [1:0]                            awburst,
  output logic                                  awvalid,
  input  logic                                  awready,
  output logic [DATA_W-1:0]                     wdata,
  output logic [DATA_W/8-1:0]                   wstrb,
  output logic                                  wlast,
  output logic                                  wvalid,
  input  logic                                  wready,
  input  logic [ID_W-1:0]                       bid,
  input  logic [1:0]                            bresp,
  input  logic                                  bvalid,
  output logic                                  bready,
  output logic                                  done_valid,
  output logic [1:0]                            done_resp,
  output logic                                  busy
`ifdef APB2AXI_WR_ERR_CNT_EN
  ,
  output logic [7:0]                            err_cnt
`endif
);

  localparam int STRB_W      = DATA_W / 8;
  localparam int ENTRY_WIDTH = ADDR_W + DATA_W + STRB_W;
  localparam logic [2:0] AW_SIZE = 3'($clog2(STRB_W));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [STRB_W-1:0]   strb_q;

  // A channel counts as finished if its valid is already low or its
  // transfer completes on this edge.
  logic aw_ok;
  logic w_ok;
  assign aw_ok = !awvalid || awready;
  assign w_ok  = !wvalid  || wready;

  // The response ID is not checked: only one write is ever outstanding.
  logic unused_bid;
  assign unused_bid = ^bid;

  // Handshake readies depend on state only, so no input feeds an output
  // combinationally.
  assign cmd_ready = (state == IDLE);
  assign bready    = (state == RESP);
  assign busy      = (state != IDLE);

  assign awid    = ID_W'(AXI_ID);
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = AW_SIZE;
  assign awburst = 2'b01;
  assign wdata   = data_q;
  assign wstrb   = strb_q;
  assign wlast   = wvalid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      done_valid <= 1'b0;
      done_resp  <= 2'b00;
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_data[ADDR_W-1:0];
            data_q  <= cmd_data[ADDR_W +: DATA_W];
            strb_q  <= cmd_data[ADDR_W+DATA_W +: STRB_W];
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (aw_ok && w_ok)      state   <= RESP;
        end
        RESP: begin
          if (bvalid) begin
            done_valid <= 1'b1;
            done_resp  <= bresp;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef APB2AXI_WR_ERR_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_cnt <= 8'd0;
    end else if ((state == RESP) && bvalid && bresp[1] && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

  // The full entry width must match the port width.
  logic [ENTRY_WIDTH-1:0] unused_entry;
  assign unused_entry = cmd_data;

endmodule

// File: doc/apb2axi_wr_issuer.md
APB2AXI_WR_ISSUER -- requirements
Module: apb2axi_wr_issuer

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, AXI data width; legal values are 32 and 64.
REQ-003 The module SHALL have parameter ID_W, default 4, AXI ID width.
REQ-004 The module SHALL have parameter AXI_ID, default 0, the constant ID driven on awid.
REQ-005 The module SHALL derive localparam ENTRY_WIDTH = ADDR_W+DATA_W+DATA_W/8, with entry layout {strb, data, addr} and addr in the LSBs.
REQ-006 The module SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock
- resetn  in  1  async active-low reset
- cmd_valid  in  1  command-FIFO pop_valid
- cmd_ready  out  1  command-FIFO pop_ready
- cmd_data  in  ENTRY_WIDTH  command-FIFO pop_data
- awid/awaddr/awlen/awsize/awburst  out  ID_W/ADDR_W/8/3/2  AXI AW payload
- awvalid  out  1; awready  in  1
- wdata/wstrb/wlast  out  DATA_W/DATA_W/8/1  AXI W payload
- wvalid  out  1; wready  in  1
- bid/bresp  in  ID_W/2  AXI B payload
- bvalid  in  1; bready  out  1
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  bresp of the completed write
- busy  out  1  high when state != IDLE
- err_cnt  out  8  error count; present only with APB2AXI_WR_ERR_CNT_EN

Function
REQ-007 The FSM SHALL have three states, IDLE, ISSUE and RESP, and SHALL take these transitions:
- IDLE->ISSUE on cmd_valid&&cmd_ready
- ISSUE->RESP when both the AW and W handshakes have completed
- RESP->IDLE on bvalid&&bready
REQ-008 cmd_ready SHALL be 1 only in IDLE (a combinational function of state only), and cmd_data SHALL be registered on the handshake.
REQ-009 awvalid and wvalid SHALL both assert in the cycle after the cmd handshake (latency 1), with payload from the registered entry.
REQ-010 awvalid SHALL stay high with a stable payload until awready is sampled high, then deassert the next cycle; wvalid SHALL behave the same way, independently, with wready.
REQ-011 An AW and W handshake in the same cycle SHALL move the FSM to RESP the next cycle; if they land in different cycles, the FSM SHALL move to RESP the cycle after the later one.
REQ-012 The AW payload SHALL be fixed as follows:
- awlen=0
- awsize=$clog2(DATA_W/8)
- awburst=2'b01 (INCR)
- awid=AXI_ID
REQ-013 wlast SHALL equal 1 whenever wvalid is 1.
REQ-014 bready SHALL be 1 only in RESP.
REQ-015 bvalid outside RESP SHALL be ignored and SHALL cause no state change.
REQ-016 bid SHALL NOT be checked.
REQ-017 On the B handshake, done_valid SHALL pulse for exactly one cycle in the following cycle, with done_resp=bresp.
REQ-018 cmd_ready SHALL be 1 in the same cycle as the done_valid pulse.
REQ-019 At most one write SHALL be outstanding.
REQ-020 Minimum command-to-command spacing SHALL be 3 cycles (IDLE, ISSUE, RESP).
REQ-021 No output SHALL depend combinationally on awready, wready or bvalid.

Reset
REQ-022 When resetn=0, the block SHALL asynchronously force the following:
- state=IDLE
- awvalid, wvalid, bready, done_valid = 0
- done_resp=0
- all payload registers = 0
- err_cnt=0
REQ-023 Reset asserted mid-transaction SHALL abandon that transaction without completion and without a done_valid pulse.
REQ-024 cmd_ready SHALL be 1 in the first cycle after resetn deasserts.

Configuration
REQ-025 With macro APB2AXI_WR_ERR_CNT_EN defined, err_cnt SHALL increment by 1 on each B handshake with bresp[1]=1 (SLVERR or DECERR) and SHALL saturate at 8'hFF.
REQ-026 Without APB2AXI_WR_ERR_CNT_EN, the err_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 The bench SHALL cover:
- Basic write: cmd {strb=4'hF, data=32'hDEADBEEF, addr=32'h1000}, awready=wready=1, bvalid=1 with bresp=0 -> awaddr=0x1000 and wdata=0xDEADBEEF one cycle after the cmd handshake; done_valid pulses with done_resp=0; 3 cycles total.
- Split handshakes: awready=1 at cycle 1, wready held 0 until cycle 4 -> awvalid drops after cycle 1; wvalid and wdata stay stable through cycle 4; RESP is entered at cycle 5.
- Backpressure on B: bvalid delayed 10 cycles -> bready stays high, cmd_ready stays 0, busy=1 throughout.
- Back-to-back: 4 queued commands, all readies at 1 -> 4 done_valid pulses spaced exactly 3 cycles apart, addresses in order.
- Reset mid-ISSUE: resetn=0 while awvalid=1 -> awvalid and wvalid drop immediately; no done_valid pulse; cmd_ready=1 after release.
- Error count (macro on): 300 writes with bresp=2'b10 -> err_cnt=0xFF; writes with bresp=0 leave it unchanged.
